// File: rtl/nvdla_glb_intr_coalesce.sv
// GLB interrupt coalescer: sticky per-source status with SW set / W1C,
// per-bit mask, and a direct or count/timeout coalesced core interrupt.
// Optional overflow tracking is built when NVDLA_GLB_INTR_OVF_EN is defined;
// otherwise src_ovf is tied to 0 and no overflow flops exist.

// Per-source sticky status bit; exports its next value so the top can
// build the same-cycle active term without duplicating the priority logic.
module nvdla_glb_intr_bit (
    input  logic nvdla_core_clk,
    input  logic nvdla_core_rst,
    input  logic src_q,
    input  logic set_i,
    input  logic clr_i,
    output logic status_nxt,
    output logic status
);
    // set (HW or SW) beats clear
    assign status_nxt = (src_q | set_i) ? 1'b1 : (clr_i ? 1'b0 : status);

    // status register
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) status <= 1'b0;
        else                status <= status_nxt;
    end
endmodule

module nvdla_glb_intr_coalesce #(
    parameter int NUM_SRC = 16,
    parameter int CNT_W   = 8,
    parameter int TMR_W   = 16
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [NUM_SRC-1:0] src_pulse,
    input  logic               sw_set_vld,
    input  logic               sw_clr_vld,
    input  logic [NUM_SRC-1:0] sw_wdat,
    input  logic [NUM_SRC-1:0] mask,
    input  logic               cfg_coal_en,
    input  logic [CNT_W-1:0]   cfg_coal_thresh,
    input  logic [TMR_W-1:0]   cfg_coal_timeout,
    output logic [NUM_SRC-1:0] status,
    output logic [NUM_SRC-1:0] src_ovf,
    output logic               core_intr
);
    localparam int EVT_W = $clog2(NUM_SRC + 1);
    localparam int SUM_W = ((CNT_W > EVT_W) ? CNT_W : EVT_W) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TMR_W-1:0] TMR_MAX = '1;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_ASSERT} state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] status_nxt;
    logic [NUM_SRC-1:0] set_v, clr_v;
    logic [CNT_W-1:0]   evt_cnt, evt_cnt_nxt, evt_base, cnt_sum, thresh_eff;
    logic [TMR_W-1:0]   timer, timer_nxt, timer_inc;
    logic [SUM_W-1:0]   cnt_sum_w;
    logic [EVT_W-1:0]   new_evt;
    logic               active_nxt;
    logic               core_intr_nxt;

    assign set_v = {NUM_SRC{sw_set_vld}} & sw_wdat;
    assign clr_v = {NUM_SRC{sw_clr_vld}} & sw_wdat;

    // single input flop stage on the engine done pulses
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) src_q <= '0;
        else                src_q <= src_pulse;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_bit
            nvdla_glb_intr_bit u_bit (
                .nvdla_core_clk (nvdla_core_clk),
                .nvdla_core_rst (nvdla_core_rst),
                .src_q          (src_q[gi]),
                .set_i          (set_v[gi]),
                .clr_i          (clr_v[gi]),
                .status_nxt     (status_nxt[gi]),
                .status         (status[gi])
            );
        end
    endgenerate

    assign active_nxt = |(status_nxt & ~mask);

    // count unmasked HW events this cycle (SW sets never count)
    always_comb begin
        new_evt = '0;
        for (int i = 0; i < NUM_SRC; i++)
            new_evt = new_evt + EVT_W'(src_q[i] & ~mask[i]);
    end

    // saturating accumulate; IDLE starts from zero so one adder serves both
    assign evt_base   = (state == ST_ACCUM) ? evt_cnt : '0;
    assign cnt_sum_w  = SUM_W'(evt_base) + SUM_W'(new_evt);
    assign cnt_sum    = (cnt_sum_w > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum_w[CNT_W-1:0];
    assign timer_inc  = (timer == TMR_MAX) ? TMR_MAX : timer + TMR_W'(1);
    assign thresh_eff = (cfg_coal_thresh == '0) ? CNT_W'(1) : cfg_coal_thresh;

    // coalescing next-state; leaving to IDLE always clears the counters
    always_comb begin
        state_nxt   = state;
        evt_cnt_nxt = evt_cnt;
        timer_nxt   = timer;
        if (!cfg_coal_en) begin
            state_nxt   = ST_IDLE;
            evt_cnt_nxt = '0;
            timer_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_evt != '0) begin
                        evt_cnt_nxt = cnt_sum;
                        timer_nxt   = '0;
                        state_nxt   = (cnt_sum >= thresh_eff) ? ST_ASSERT : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    evt_cnt_nxt = cnt_sum;
                    timer_nxt   = timer_inc;
                    if (!active_nxt) begin
                        state_nxt   = ST_IDLE;
                        evt_cnt_nxt = '0;
                        timer_nxt   = '0;
                    end else if ((cnt_sum >= thresh_eff) ||
                                 ((cfg_coal_timeout != '0) && (timer_inc >= cfg_coal_timeout))) begin
                        state_nxt = ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (!active_nxt) begin
                        state_nxt   = ST_IDLE;
                        evt_cnt_nxt = '0;
                        timer_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    evt_cnt_nxt = '0;
                    timer_nxt   = '0;
                end
            endcase
        end
    end

    assign core_intr_nxt = cfg_coal_en ? (state_nxt == ST_ASSERT) : active_nxt;

    // FSM, counters and registered interrupt
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state     <= ST_IDLE;
            evt_cnt   <= '0;
            timer     <= '0;
            core_intr <= 1'b0;
        end else begin
            state     <= state_nxt;
            evt_cnt   <= evt_cnt_nxt;
            timer     <= timer_nxt;
            core_intr <= core_intr_nxt;
        end
    end

`ifdef NVDLA_GLB_INTR_OVF_EN
    // overflow: a new pulse lands on an already-set bit with no clear pending
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) src_ovf <= '0;
        else                src_ovf <= (src_q & status & ~clr_v) | (src_ovf & ~clr_v);
    end
`else
    assign src_ovf = '0;
`endif

endmodule
